u_wallace_pipe_mul: RTL

- Parametrised, 3-stage pipelined Wallace-tree multiplier for N-bit operands.
- Per-transaction unsigned/signed mode: signed uses Baugh-Wooley two's-complement partial products.
- CSA reduction with a ripple-carry final adder, wrapped in a valid/ready streaming handshake with backpressure.
- Next-generation arithmetic core for datapaths that need throughput of one product per clock rather than a single combinational multiply.

---
 rtl/u_wallace_pipe_mul.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/u_wallace_pipe_mul.sv
// Three-stage pipelined Wallace-tree multiplier with a valid/ready stream interface.
// Signed mode uses Baugh-Wooley partial products; rows are reduced by 3:2 CSA layers.
module u_wallace_pipe_mul #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);
  localparam int W = 2 * N;
  localparam int R = N + 1;

  // Number of 3:2 layers needed to bring R rows down to two.
  function automatic int num_layers(input int rows);
    int c;
    int l;
    c = rows;
    l = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + (c % 3);
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LAYERS = num_layers(R);

  logic         adv_s;
  logic         v1_r;
  logic         v2_r;
  logic         out_valid_r;
  logic [N-1:0] a_r;
  logic [N-1:0] b_r;
  logic         sgn_r;
  logic [W-1:0] sum_s;
  logic [W-1:0] carry_s;
  logic [W-1:0] sum_r;
  logic [W-1:0] carry_r;
  logic [W-1:0] final_s;
  logic [W-1:0] out_r;

  assign adv_s     = ~(out_valid_r & ~out_ready);
  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign busy      = v1_r | v2_r | out_valid_r;

  // Stage 1: capture operands on accept; an advance without accept leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sgn_r <= 1'b0;
    end else if (adv_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        a_r   <= a;
        b_r   <= b;
        sgn_r <= is_signed;
      end
    end
  end

  // Partial-product generation and CSA reduction down to a sum row and a carry row.
  always_comb begin : csa_tree
    logic [W-1:0] rows [R];
    logic [W-1:0] nxt  [R];
    logic         pp;
    int           cnt;
    int           ng;
    int           left;
    for (int r = 0; r < R; r++) begin
      rows[r] = '0;
      nxt[r]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp = a_r[j] & b_r[i];
        if (sgn_r && ((i == N - 1) != (j == N - 1))) begin
          rows[i][i+j] = ~pp;
        end else begin
          rows[i][i+j] = pp;
        end
      end
    end
    rows[N][N]   = sgn_r;
    rows[N][W-1] = sgn_r;
    cnt = R;
    for (int l = 0; l < LAYERS; l++) begin
      ng   = cnt / 3;
      left = cnt - 3 * ng;
      for (int r = 0; r < R; r++) begin
        nxt[r] = '0;
      end
      for (int g = 0; g < R / 3; g++) begin
        nxt[2*g]   = (g < ng) ? (rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2]) : '0;
        nxt[2*g+1] = (g < ng) ? (((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                                  (rows[3*g+1] & rows[3*g+2])) << 1) : '0;
      end
      for (int k = 0; k < 2; k++) begin
        if (k < left) begin
          nxt[2*ng+k] = rows[3*ng+k];
        end else begin
          pp = 1'b0;
        end
      end
      for (int r = 0; r < R; r++) begin
        rows[r] = nxt[r];
      end
      cnt = 2 * ng + left;
    end
    sum_s   = rows[0];
    carry_s = rows[1];
  end

  // Stage 2: register the two remaining rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r    <= 1'b0;
      sum_r   <= '0;
      carry_r <= '0;
    end else if (adv_s) begin
      v2_r    <= v1_r;
      sum_r   <= sum_s;
      carry_r <= carry_s;
    end
  end

  // Ripple-carry final adder; the carry out of the top bit is dropped (mod 2^2N).
  always_comb begin : ripple_add
    logic c;
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      final_s[i] = sum_r[i] ^ carry_r[i] ^ c;
      c          = (sum_r[i] & carry_r[i]) | (c & (sum_r[i] ^ carry_r[i]));
    end
  end

  // Stage 3: product register; keeps its last value when no transaction arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else if (adv_s) begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        out_r <= final_s;
      end
    end
  end

endmodule
